// File: rtl/noc_packet_tx.sv
// noc_packet_tx
// Tile-side packet transmitter for the router's local input port.
// Takes a message descriptor plus payload words over ready/valid, builds
// the head flit and serializes head/payload flits into a one-flit output
// register that speaks the void/stop flit protocol.
// Optional build macro: NOC_TX_WATCHDOG_EN adds a sticky stall watchdog
// on stall_err; without it stall_err is tied low.

module noc_packet_tx #(
  parameter int Width      = 34,
  parameter int LenWidth   = 8,
  parameter int StallLimit = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          CONST_localx,
  input  logic [2:0]          CONST_localy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_dest_x,
  input  logic [2:0]          req_dest_y,
  input  logic [4:0]          req_msg_type,
  input  logic [LenWidth-1:0] req_len,
  input  logic                pay_valid,
  output logic                pay_ready,
  input  logic [Width-3:0]    pay_data,
  output logic [Width-1:0]    noc_data_out,
  output logic                noc_void_out,
  input  logic                noc_stop_in,
  output logic                stall_err
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t              state;
  logic [LenWidth-1:0] count;
  logic [Width-1:0]    or_data;
  logic                or_void;

  logic                consume;
  logic                can_load;
  logic                req_fire;
  logic                pay_fire;
  logic                last_pay;
  logic [Width-1:0]    head_flit;
  logic [Width-1:0]    pay_flit;

  assign noc_data_out = or_data;
  assign noc_void_out = or_void;

  // The router takes the held flit whenever one is present and stop is low.
  // A held stop freezes the output register, so nothing loads under stop.
  assign consume  = !or_void && !noc_stop_in;
  assign can_load = (or_void || consume) && !noc_stop_in;

  // Readiness is derived only from state, stop and register occupancy,
  // and is forced low while reset is asserted.
  assign req_ready = !rst && (state == IDLE)    && can_load;
  assign pay_ready = !rst && (state == PAYLOAD) && can_load;

  assign req_fire = req_valid && req_ready;
  assign pay_fire = pay_valid && pay_ready;

  assign last_pay = (count == LenWidth'(1));

  // Head flit: preamble, then src y/x, dst y/x, type and length packed
  // from the top of the payload field downward, zeros below.
  always_comb begin
    head_flit                  = '0;
    head_flit[Width-1]         = 1'b1;
    head_flit[Width-2]         = (req_len == '0);
    head_flit[Width-3 -: 3]    = CONST_localy;
    head_flit[Width-6 -: 3]    = CONST_localx;
    head_flit[Width-9 -: 3]    = req_dest_y;
    head_flit[Width-12 -: 3]   = req_dest_x;
    head_flit[Width-15 -: 5]   = req_msg_type;
    head_flit[Width-20 -: LenWidth] = req_len;
  end

  // Payload flit carries the word unchanged; tail marks the final word.
  assign pay_flit = {1'b0, last_pay, pay_data};

  // Packet FSM and output register: load a new flit when allowed, otherwise
  // go void once the held flit has been consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      or_data <= '0;
      or_void <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            or_data <= head_flit;
            or_void <= 1'b0;
            count   <= req_len;
            state   <= (req_len == '0) ? IDLE : PAYLOAD;
          end else if (consume) begin
            or_void <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (pay_fire) begin
            or_data <= pay_flit;
            or_void <= 1'b0;
            count   <= count - LenWidth'(1);
            if (last_pay) begin
              state <= IDLE;
            end
          end else if (consume) begin
            or_void <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NOC_TX_WATCHDOG_EN
  localparam int CntWidth = $clog2(StallLimit + 1);

  logic [CntWidth-1:0] stall_cnt;
  logic                stall_q;

  assign stall_err = stall_q;

  // Stall watchdog: count cycles a flit sits blocked by stop, saturating,
  // and latch an error once the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else if (consume) begin
      stall_cnt <= '0;
    end else if (!or_void && noc_stop_in) begin
      if (stall_cnt < CntWidth'(StallLimit)) begin
        stall_cnt <= stall_cnt + CntWidth'(1);
      end
      if (stall_cnt >= CntWidth'(StallLimit - 1)) begin
        stall_q <= 1'b1;
      end
    end
  end
`else
  logic unused_stall_limit;

  assign unused_stall_limit = (StallLimit != 0);
  assign stall_err          = 1'b0;
`endif

endmodule

// File: tb/tb_noc_packet_tx.sv
// tb_noc_packet_tx
// Directed self-checking bench for noc_packet_tx (Width 34, LenWidth 8,
// StallLimit 8). Local tile is (x=2, y=1).

module tb_noc_packet_tx;

  logic        clk;
  logic        rst;
  logic [2:0]  CONST_localx;
  logic [2:0]  CONST_localy;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_dest_x;
  logic [2:0]  req_dest_y;
  logic [4:0]  req_msg_type;
  logic [7:0]  req_len;
  logic        pay_valid;
  logic        pay_ready;
  logic [31:0] pay_data;
  logic [33:0] noc_data_out;
  logic        noc_void_out;
  logic        noc_stop_in;
  logic        stall_err;

  int checks;
  int errors;

  noc_packet_tx #(
    .Width(34),
    .LenWidth(8),
    .StallLimit(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .CONST_localx(CONST_localx),
    .CONST_localy(CONST_localy),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dest_x(req_dest_x),
    .req_dest_y(req_dest_y),
    .req_msg_type(req_msg_type),
    .req_len(req_len),
    .pay_valid(pay_valid),
    .pay_ready(pay_ready),
    .pay_data(pay_data),
    .noc_data_out(noc_data_out),
    .noc_void_out(noc_void_out),
    .noc_stop_in(noc_stop_in),
    .stall_err(stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected head flit for local tile (2,1), built field by field.
  function automatic logic [33:0] mk_head(input logic [2:0] dx, input logic [2:0] dy,
                                          input logic [4:0] t, input logic [7:0] len);
    logic tl;
    tl = (len == 8'd0);
    return {1'b1, tl, 3'd1, 3'd2, dy, dx, t, len, 7'b0};
  endfunction

  function automatic logic [33:0] mk_pay(input logic tl, input logic [31:0] d);
    return {1'b0, tl, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [2:0] dx, input logic [2:0] dy,
                         input logic [4:0] t, input logic [7:0] len);
    req_valid    = v;
    req_dest_x   = dx;
    req_dest_y   = dy;
    req_msg_type = t;
    req_len      = len;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_void got %b exp 1", noc_void_out); end
    checks++;
    if (noc_data_out !== 34'd0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", noc_data_out); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++;
    if (pay_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pay_ready got %b exp 0", pay_ready); end
    checks++;
    if (stall_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_err got %b exp 0", stall_err); end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_len0();
    set_req(1'b1, 3'd5, 3'd3, 5'h04, 8'd0);
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    checks++;
    if (noc_void_out !== 1'b0) begin errors++; $display("[TB] FAIL len0_void got %b exp 0", noc_void_out); end
    checks++;
    if (noc_data_out !== mk_head(3'd5, 3'd3, 5'h04, 8'd0)) begin
      errors++; $display("[TB] FAIL len0_head got %h exp %h", noc_data_out, mk_head(3'd5, 3'd3, 5'h04, 8'd0));
    end
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL len0_void_after got %b exp 1", noc_void_out); end
  endtask

  task automatic test_len3();
    logic [31:0] words [3];
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    set_req(1'b1, 3'd4, 3'd6, 5'h11, 8'd3);
    pay_valid = 1'b1;
    pay_data  = words[0];
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    checks++;
    if (noc_data_out !== mk_head(3'd4, 3'd6, 5'h11, 8'd3) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL len3_head got %h void %b exp %h", noc_data_out, noc_void_out, mk_head(3'd4, 3'd6, 5'h11, 8'd3));
    end
    checks++;
    if (pay_ready !== 1'b1) begin errors++; $display("[TB] FAIL len3_pay_ready got %b exp 1", pay_ready); end
    for (int i = 0; i < 3; i++) begin
      pay_data = words[i];
      step();
      checks++;
      if (noc_data_out !== mk_pay(i == 2, words[i]) || noc_void_out !== 1'b0) begin
        errors++; $display("[TB] FAIL len3_pay%0d got %h void %b exp %h", i, noc_data_out, noc_void_out, mk_pay(i == 2, words[i]));
      end
    end
    pay_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL len3_back_idle_ready got %b exp 1", req_ready); end
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL len3_void_after got %b exp 1", noc_void_out); end
  endtask

  task automatic test_stop_stall();
    set_req(1'b1, 3'd4, 3'd6, 5'h11, 8'd3);
    pay_valid = 1'b1;
    pay_data  = 32'hA;
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    step();
    pay_data = 32'hB;
    step();
    pay_data    = 32'hC;
    noc_stop_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (noc_data_out !== mk_pay(1'b0, 32'hB) || noc_void_out !== 1'b0 || pay_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold%0d got %h void %b pay_ready %b exp %h", i, noc_data_out, noc_void_out, pay_ready, mk_pay(1'b0, 32'hB));
      end
      step();
    end
    noc_stop_in = 1'b0;
    #1;
    checks++;
    if (noc_data_out !== mk_pay(1'b0, 32'hB) || pay_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release got %h pay_ready %b exp %h", noc_data_out, pay_ready, mk_pay(1'b0, 32'hB));
    end
    step();
    pay_valid = 1'b0;
    checks++;
    if (noc_data_out !== mk_pay(1'b1, 32'hC) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_tail got %h void %b exp %h", noc_data_out, noc_void_out, mk_pay(1'b1, 32'hC));
    end
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL stall_void_after got %b exp 1", noc_void_out); end
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 3'd1, 3'd0, 5'h02, 8'd1);
    pay_valid = 1'b1;
    pay_data  = 32'h11;
    step();
    checks++;
    if (noc_data_out !== mk_head(3'd1, 3'd0, 5'h02, 8'd1)) begin
      errors++; $display("[TB] FAIL b2b_head0 got %h exp %h", noc_data_out, mk_head(3'd1, 3'd0, 5'h02, 8'd1));
    end
    set_req(1'b1, 3'd7, 3'd2, 5'h1A, 8'd1);
    step();
    checks++;
    if (noc_data_out !== mk_pay(1'b1, 32'h11) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_tail0 got %h void %b exp %h", noc_data_out, noc_void_out, mk_pay(1'b1, 32'h11));
    end
    pay_data = 32'h22;
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    checks++;
    if (noc_data_out !== mk_head(3'd7, 3'd2, 5'h1A, 8'd1) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_head1 got %h void %b exp %h", noc_data_out, noc_void_out, mk_head(3'd7, 3'd2, 5'h1A, 8'd1));
    end
    step();
    pay_valid = 1'b0;
    checks++;
    if (noc_data_out !== mk_pay(1'b1, 32'h22) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_tail1 got %h void %b exp %h", noc_data_out, noc_void_out, mk_pay(1'b1, 32'h22));
    end
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_void_after got %b exp 1", noc_void_out); end
  endtask

  task automatic test_reset_mid_packet();
    set_req(1'b1, 3'd3, 3'd3, 5'h05, 8'd3);
    pay_valid = 1'b1;
    pay_data  = 32'h1;
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || pay_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_ready_in_reset got req %b pay %b exp 0 0", req_ready, pay_ready);
    end
    step();
    checks++;
    if (noc_void_out !== 1'b1 || req_ready !== 1'b0 || pay_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_cleared got void %b req %b pay %b exp 1 0 0", noc_void_out, req_ready, pay_ready);
    end
    rst       = 1'b0;
    pay_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || pay_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_idle_ready got req %b pay %b exp 1 0", req_ready, pay_ready);
    end
    set_req(1'b1, 3'd7, 3'd7, 5'h1F, 8'd0);
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    checks++;
    if (noc_data_out !== mk_head(3'd7, 3'd7, 5'h1F, 8'd0) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_new_pkt got %h void %b exp %h", noc_data_out, noc_void_out, mk_head(3'd7, 3'd7, 5'h1F, 8'd0));
    end
    step();
    checks++;
    if (noc_void_out !== 1'b1) begin errors++; $display("[TB] FAIL midrst_void_after got %b exp 1", noc_void_out); end
  endtask

  task automatic test_watchdog();
    logic exp_err;
`ifdef NOC_TX_WATCHDOG_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    set_req(1'b1, 3'd2, 3'd5, 5'h09, 8'd0);
    step();
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    noc_stop_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (stall_err !== 1'b0) begin errors++; $display("[TB] FAIL wd_before_limit got %b exp 0", stall_err); end
    step();
    checks++;
    if (stall_err !== exp_err) begin errors++; $display("[TB] FAIL wd_at_limit got %b exp %b", stall_err, exp_err); end
    checks++;
    if (noc_data_out !== mk_head(3'd2, 3'd5, 5'h09, 8'd0) || noc_void_out !== 1'b0) begin
      errors++; $display("[TB] FAIL wd_flit_held got %h void %b exp %h", noc_data_out, noc_void_out, mk_head(3'd2, 3'd5, 5'h09, 8'd0));
    end
    noc_stop_in = 1'b0;
    step();
    step();
    checks++;
    if (stall_err !== exp_err || noc_void_out !== 1'b1) begin
      errors++; $display("[TB] FAIL wd_sticky got err %b void %b exp %b 1", stall_err, noc_void_out, exp_err);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    CONST_localx = 3'd2;
    CONST_localy = 3'd1;
    noc_stop_in  = 1'b0;
    pay_valid    = 1'b0;
    pay_data     = 32'd0;
    set_req(1'b0, 3'd0, 3'd0, 5'h00, 8'd0);
    test_reset();
    test_len0();
    test_len3();
    test_stop_stall();
    test_back_to_back();
    test_reset_mid_packet();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_packet_tx.md
# noc_packet_tx

Tile-side packet transmitter for the lookahead router's local (P) input port. It accepts a message descriptor and its payload words from the tile over ready/valid handshakes and builds the head flit (coordinates, message type, length). It then serializes head and payload flits onto the router's `data_p_in` / `data_void_in[P]` lines, obeying the router's `stop_out[P]` backpressure. It is the injecting end of the same void/stop flit protocol the router ports speak.

## Interface
Parameters:
- `Width`, 34: flit width including the 2-bit preamble {head, tail}; payload field is `Width-2`.
- `LenWidth`, 8: width of the payload-length field; requires `Width >= 19 + LenWidth`.
- `StallLimit`, 1024: watchdog threshold in cycles (used only with `NOC_TX_WATCHDOG_EN`).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `CONST_localx`  in  3  local tile x; static.
- `CONST_localy`  in  3  local tile y; static.
- `req_valid`  in  1  descriptor valid.
- `req_ready`  out  1  descriptor accepted when `req_valid & req_ready`.
- `req_dest_x`  in  3  destination x.
- `req_dest_y`  in  3  destination y.
- `req_msg_type`  in  5  message type.
- `req_len`  in  LenWidth  number of payload flits (0 is legal).
- `pay_valid`  in  1  payload word valid.
- `pay_ready`  out  1  payload word accepted when `pay_valid & pay_ready`.
- `pay_data`  in  Width-2  payload word.
- `noc_data_out`  out  Width  flit to router `data_p_in`.
- `noc_void_out`  out  1  1 = no flit; to router `data_void_in[P]`.
- `noc_stop_in`  in  1  router `stop_out[P]`; 1 = flit not accepted this cycle.
- `stall_err`  out  1  sticky watchdog error.

## Operation
- Flit bits: `[Width-1]` = head, `[Width-2]` = tail.
- Head flit fields from `[Width-3]` downward: src y(3), src x(3), dst y(3), dst x(3), msg type(5), len(LenWidth). The remaining LSBs are 0.
- Payload flit: head = 0, `[Width-3:0]` = `pay_data`. Tail = 1 on the last payload flit.
- `req_len` = 0 produces a single flit with head = 1 and tail = 1.
- Output register (OR): holds one flit. It is empty when `noc_void_out` = 1.
- A flit is consumed in any cycle with `noc_void_out = 0` and `noc_stop_in = 0`.
- OR "can load" = empty, or consumed this cycle.
- FSM states:
  - IDLE: `req_ready` = can load. On accept, load the head flit into OR, latch the remaining count = `req_len`, go to PAYLOAD. If `req_len` = 0, stay in IDLE instead.
  - PAYLOAD: `pay_ready` = can load. On accept, load the payload flit and decrement the count. When the count reaches 0, set tail and go to IDLE.
- `req_ready` is 0 outside IDLE. `pay_ready` is 0 outside PAYLOAD.
- If nothing loads and OR is consumed, `noc_void_out` goes to 1.
- While `noc_stop_in` = 1, OR contents and `noc_void_out` stay constant.

## Timing
- Reset values: `noc_void_out` = 1, `noc_data_out` = 0, `req_ready` = 0, `pay_ready` = 0, `stall_err` = 0. FSM = IDLE, count = 0.
- `req_ready` rises in the first cycle after `rst` deasserts.
- Latency: descriptor accepted in cycle N → head flit on `noc_data_out` in N+1.
- Throughput: 1 flit per cycle with `noc_stop_in` = 0 and `pay_valid` held high. A packet of len L occupies L+1 consecutive cycles.
- Back-to-back packets: the next head flit may follow the previous tail with zero void cycles.
- A simultaneous consume and load replaces OR in the same edge, with no bubble.
- `req_ready` and `pay_ready` are combinational from `noc_stop_in` and OR state. There is no combinational path from `req_valid`/`pay_valid` to any output.
- Reset mid-packet: all state clears next edge and the partial packet is abandoned without a tail. The system ensures the router is reset together with this block.
- Count arithmetic is unsigned LenWidth. The maximum length is 2^LenWidth−1, and there is no wrap.

## Configuration
- `NOC_TX_WATCHDOG_EN`:
  - Defined: a stall counter increments each cycle with `noc_void_out = 0` and `noc_stop_in = 1`, and clears on consume. When it reaches `StallLimit`, `stall_err` sets and stays set until `rst`. The counter saturates.
  - Undefined: no counter is built and `stall_err` is tied to 0.

## Test plan
- Local (2,1), descriptor dest (5,3), type 0x04, len 0 → one flit next cycle with head = 1, tail = 1. Fields match: src y1 x2, dst y3 x5, type 4, len 0. `noc_void_out` returns to 1 the following cycle.
- len 3, payload 0xA, 0xB, 0xC, stop low → 4 consecutive flits. Head = 1 only on flit 0; tail = 1 only on the 0xC flit; data matches in order.
- Same packet with `noc_stop_in` high for 5 cycles on payload 0xB → `noc_data_out` holds 0xB for those 5 cycles and `pay_ready` = 0. Then 0xC follows with no duplicates or drops.
- Two len-1 packets back-to-back, stop low → 4 flits in 4 cycles with no void cycle between tail and next head.
- Assert `rst` while in PAYLOAD with 2 flits remaining → next cycle `noc_void_out` = 1 and ready outputs = 0. Then a new len-0 descriptor sends correctly.
- With `NOC_TX_WATCHDOG_EN` and `StallLimit` = 8, stop held high for 8 cycles → `stall_err` = 1 and remains 1 after stop drops.
